fa_exerciser: RTL and testbench
===============================

# fa_exerciser

On-chip stimulus/checker that drives the full-adder tile's dedicated inputs and decodes its seven-segment output back to a binary value. It sweeps all eight {cin,b,a} combinations, compares each decoded result against a+b+cin, and reports pass/fail. It sits on the driving side of the adder: it owns `ui_in` and reads `uo_out[6:0]`. It is used for bring-up self-test on the demo board and as a reusable bench component.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..15.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only in IDLE or DONE.
- `stim_out`  out  8  to the DUT `ui_in`; bit0=a, bit1=b, bit2=cin, bits[7:3]=0.
- `seg_in`  in  7  from the DUT `uo_out[6:0]`; bit0=seg a … bit6=seg g, active-high.
- `busy`  out  1  high from the cycle after start is accepted until the sweep ends.
- `done`  out  1  high in DONE; held until start or rst.
- `pass`  out  1  valid while done=1; 1 if err_count==0.
- `err_count`  out  4  number of failing vectors, 0..8.
- `fail_vec`  out  8  bit i set when vector i failed.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - idx←0, stim_out←0, cnt←SETTLE_CYCLES-1.
  - err_count←0, fail_vec←0, done←0, busy←1.
  - Go to SETTLE.
- SETTLE: if cnt==0, go to CHECK; otherwise cnt←cnt-1.
- CHECK: sample seg_in through the decoder.
  - Expected value = popcount(idx[2:0]), range 0..3.
  - Legal patterns: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F.
  - A vector is an error if the pattern is illegal or the decoded value is not the expected value.
  - On error: fail_vec[idx]←1 and err_count←err_count+1.
  - If idx==7: go to DONE.
  - Otherwise: idx←idx+1, stim_out←{5'b0,idx+1}, cnt←SETTLE_CYCLES-1, go to SETTLE.
- DONE: busy=0, done=1, pass=(err_count==0). stim_out holds the last vector.
- start in SETTLE or CHECK is ignored.
- Reset values: state IDLE; stim_out, busy, done, pass, err_count and fail_vec all 0.
- rst mid-sweep aborts immediately. Results are cleared.

## Timing
- Start accepted at edge 0. stim_out=0 and busy=1 are visible after edge 0.
- Each vector occupies SETTLE_CYCLES cycles in SETTLE plus 1 cycle in CHECK.
- seg_in is sampled at the CHECK-cycle edge, SETTLE_CYCLES+1 edges after stim_out changes. The DUT path must settle within SETTLE_CYCLES cycles.
- done rises 8·(SETTLE_CYCLES+1) edges after the start edge (24 edges at the default). busy falls on the same edge.
- A start sampled in DONE restarts the sweep with the same timing as a start from IDLE.
- Error flags are registered in the CHECK edge. The final vector's result is visible together with done.

## Configuration
- `FA_EXERCISER_STOP_ON_FAIL_EN` defined: the first failing CHECK goes straight to DONE.
  - Its error is recorded, so err_count≤1.
  - done rises (idx+1)·(SETTLE_CYCLES+1) edges after start.
- Undefined: the full eight-vector sweep always runs.

## Structure
- Package `fa_exerciser_pkg`:
  - state enum.
  - SEG_0..SEG_3 pattern constants.
  - `NUM_VECTORS`=8.
  - `popcount3` function.
- Sub-module `seg7_decode`: combinational; input seg[6:0], outputs valid and value[1:0]. This is the inverse of the DUT's encoder and is reused by the bench scoreboard.

## Test plan
- Ideal adder model, default parameters, start pulse → stim_out steps 0..7.
  - Each vector is held 3 cycles.
  - done at edge 24, pass=1, err_count=0, fail_vec=8'h00.
- Model drops the carry (value&1) → vectors 3,5,6,7 fail.
  - fail_vec=8'hE8, err_count=4, pass=0.
- Model outputs 7'h00 on vector 0 only → illegal-pattern error.
  - fail_vec=8'h01, err_count=1, pass=0.
- start pulsed at edge 5 while busy → ignored; done still at edge 24.
- rst at edge 10 → next cycle: all outputs 0, state IDLE.
  - A new start gives a clean 24-cycle pass.
- `FA_EXERCISER_STOP_ON_FAIL_EN` defined, fault on vector 3 only → done at edge 12.
  - fail_vec=8'h08, err_count=1, pass=0.
  - A second start from DONE clears results first.

Source files
------------

// File: rtl/fa_exerciser_pkg.sv
// Shared types and constants for the full-adder exerciser.
// Seven-segment patterns are active-high, bit0 = seg a .. bit6 = seg g.
package fa_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;

    localparam int NUM_VECTORS = 8;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/fa_exerciser_seg7_decode.sv
// Inverse of the adder tile's seven-segment encoder for digits 0..3.
// Any other pattern is reported as not valid.
module seg7_decode
    import fa_exerciser_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [1:0] value
);

    always_comb begin
        valid = 1'b1;
        value = 2'd0;
        case (seg)
            SEG_0:   value = 2'd0;
            SEG_1:   value = 2'd1;
            SEG_2:   value = 2'd2;
            SEG_3:   value = 2'd3;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fa_exerciser.sv
// Sweeps all {cin,b,a} vectors into the adder tile and checks its display.
// Define FA_EXERCISER_STOP_ON_FAIL_EN to end the sweep at the first failure.
module fa_exerciser
    import fa_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] stim_out,
    input  logic [6:0] seg_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] stim_q, stim_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fvec_q, fvec_d;

    logic       seg_valid;
    logic [1:0] seg_value;
    logic       vec_bad;
    logic       finish;

    seg7_decode u_dec (
        .seg   (seg_in),
        .valid (seg_valid),
        .value (seg_value)
    );

    assign vec_bad = !seg_valid || (seg_value != popcount3(idx_q));

`ifdef FA_EXERCISER_STOP_ON_FAIL_EN
    assign finish = (idx_q == IDX_LAST) || vec_bad;
`else
    assign finish = (idx_q == IDX_LAST);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    stim_d  = 8'd0;
                    cnt_d   = CNT_INIT;
                    err_d   = 4'd0;
                    fvec_d  = 8'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_CHECK;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_CHECK: begin
                if (vec_bad) begin
                    fvec_d[idx_q] = 1'b1;
                    err_d         = err_q + 4'd1;
                end
                if (finish) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    stim_d  = {5'b0, idx_q + 3'd1};
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            stim_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            fvec_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
        end
    end

    assign stim_out  = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fvec_q;

endmodule

// File: tb/tb_fa_exerciser.sv
// Directed bench: a behavioural adder tile with selectable faults feeds
// the exerciser; expected sweep timing and results are hand-computed.
module tb_fa_exerciser;

    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] stim_out;
    logic [6:0] seg_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    fa_exerciser #(.SETTLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stim_out  (stim_out),
        .seg_in    (seg_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    // Adder tile model: 0 ideal, 1 carry dropped, 2 blank on vector 0,
    // 3 wrong digit on vector 3.
    always_comb begin
        int v;
        v = int'(stim_out[0]) + int'(stim_out[1]) + int'(stim_out[2]);
        if (mode == 1) v = v & 1;
        if (mode == 3 && stim_out == 8'd3) v = 0;
        case (v)
            0:       seg_in = 7'h3F;
            1:       seg_in = 7'h06;
            2:       seg_in = 7'h5B;
            default: seg_in = 7'h4F;
        endcase
        if (mode == 2 && stim_out == 8'd0) seg_in = 7'h00;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start, then count edges until done. glitch/abort_at give the
    // edge number at which a stray start or a reset is sampled (0 = none).
    task automatic sweep(input string tag, input int glitch,
                         input int abort_at, output int edges);
        bit stim_ok;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        edges = 0;
        check({tag, ".busy0"}, busy, 1);
        check({tag, ".stim0"}, stim_out, 0);
        stim_ok = 1'b1;
        while (edges < 100) begin
            if (edges + 1 == glitch)   start = 1'b1;
            if (edges + 1 == abort_at) rst = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            rst   = 1'b0;
            edges++;
            if (edges == abort_at) return;
            if (done) break;
            if (stim_out != 8'((edges / 3 > 7) ? 7 : edges / 3)) stim_ok = 1'b0;
        end
        if (edges >= 100) check({tag, ".timeout"}, 1, 0);
        check({tag, ".stimseq"}, stim_ok, 1);
        check({tag, ".busyend"}, busy, 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.stim", stim_out, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.pass", pass, 0);
        check("rst.err",  err_count, 0);
        check("rst.fvec", fail_vec, 0);

        mode = 0;
        sweep("ideal", 0, 0, n);
        check("ideal.edges", n, 24);
        check("ideal.pass", pass, 1);
        check("ideal.err",  err_count, 0);
        check("ideal.fvec", fail_vec, 8'h00);

        mode = 1;
        sweep("carry", 0, 0, n);
        check("carry.edges", n, 24);
        check("carry.pass", pass, 0);
        check("carry.err",  err_count, 4);
        check("carry.fvec", fail_vec, 8'hE8);

        mode = 2;
        sweep("blank", 0, 0, n);
        check("blank.edges", n, 24);
        check("blank.pass", pass, 0);
        check("blank.err",  err_count, 1);
        check("blank.fvec", fail_vec, 8'h01);

        mode = 0;
        sweep("glitch", 5, 0, n);
        check("glitch.edges", n, 24);
        check("glitch.pass", pass, 1);

        sweep("abort", 0, 10, n);
        check("abort.edge", n, 10);
        check("abort.stim", stim_out, 0);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.pass", pass, 0);
        check("abort.err",  err_count, 0);
        check("abort.fvec", fail_vec, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort.idle", stim_out, 0);
        sweep("clean", 0, 0, n);
        check("clean.edges", n, 24);
        check("clean.pass", pass, 1);

        mode = 3;
`ifdef FA_EXERCISER_STOP_ON_FAIL_EN
        sweep("v3", 0, 0, n);
        check("v3.edges", n, 12);
        check("v3.stim", stim_out, 3);
`else
        sweep("v3", 0, 0, n);
        check("v3.edges", n, 24);
`endif
        check("v3.pass", pass, 0);
        check("v3.err",  err_count, 1);
        check("v3.fvec", fail_vec, 8'h08);

        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart.err",  err_count, 0);
        check("restart.fvec", fail_vec, 0);
        check("restart.done", done, 0);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("restart.edges", n, 24);
        check("restart.pass", pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
